// File: rtl/bg_cmd_scheduler.sv
// Round-robin command scheduler in front of one DDR bank group: tracks the open row of
// each bank and sequences PRE/ACT/RD/WR with tRP/tRCD spacing and BL-beat bursts.
module bg_cmd_scheduler #(
    parameter int ADDRWIDTH     = 17,
    parameter int BANKSPERGROUP = 2,
    parameter int COLS          = 1024,
    parameter int BL            = 8,
    parameter int NREQ          = 2,
    parameter int TRP           = 3,
    parameter int TRCD          = 3,
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
    localparam int CADDRWIDTH   = $clog2(COLS),
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            halt,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_write,
    input  logic [NREQ*(BAWIDTH+1)-1:0]     req_ba,
    input  logic [NREQ*ADDRWIDTH-1:0]       req_row,
    input  logic [NREQ*CADDRWIDTH-1:0]      req_col,
    output logic [NREQ-1:0]                 req_ready,
    output logic [18:0]                     commands,
    output logic [BAWIDTH:0]                ba,
    output logic [ADDRWIDTH-1:0]            row,
    output logic [CADDRWIDTH-1:0]           column,
    output logic                            dq_oe,
    output logic                            busy,
    output logic                            done,
    output logic [IDW-1:0]                  done_id
);

    localparam int LBW  = $clog2(BL);
    localparam int CNTW = (TRP > TRCD) ? $clog2(TRP + 1) : $clog2(TRCD + 1);

    typedef enum logic [2:0] {StIdle, StPre, StWaitRp, StAct, StWaitRcd, StBurst} state_e;

    state_e                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [LBW-1:0]         beat_q, beat_d;
    logic [IDW-1:0]         lat_id_q, lat_id_d;
    logic                   lat_write_q, lat_write_d;
    logic [BAWIDTH:0]       lat_ba_q, lat_ba_d;
    logic [ADDRWIDTH-1:0]   lat_row_q, lat_row_d;
    logic [CADDRWIDTH-1:0]  lat_col_q, lat_col_d;

    logic [BANKSPERGROUP-1:0] open_valid_q, open_valid_d;
    logic [ADDRWIDTH-1:0]     open_row_q [BANKSPERGROUP];
    logic [ADDRWIDTH-1:0]     open_row_d [BANKSPERGROUP];

    logic [NREQ-1:0]        req_ready_d;
    logic [18:0]            commands_d;
    logic [BAWIDTH:0]       ba_d;
    logic [ADDRWIDTH-1:0]   row_d;
    logic [CADDRWIDTH-1:0]  column_d;
    logic                   dq_oe_d, busy_d, done_d;
    logic [IDW-1:0]         done_id_d;

    logic                   grant_found;
    logic [IDW-1:0]         grant_id;
    logic [BAWIDTH:0]       g_ba;
    logic [ADDRWIDTH-1:0]   g_row;
    logic [CADDRWIDTH-1:0]  g_col;
    logic [BAWIDTH-1:0]     g_bank, lat_bank;

    // Lowest valid index overall, then overridden by the lowest valid index >= pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDW'(i) >= ptr_q)) begin
                grant_id = IDW'(i);
            end
        end
    end

    assign g_ba     = req_ba[int'(grant_id)*(BAWIDTH+1) +: (BAWIDTH+1)];
    assign g_row    = req_row[int'(grant_id)*ADDRWIDTH +: ADDRWIDTH];
    assign g_col    = req_col[int'(grant_id)*CADDRWIDTH +: CADDRWIDTH];
    assign g_bank   = g_ba[BAWIDTH-1:0];
    assign lat_bank = lat_ba_q[BAWIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        lat_id_d     = lat_id_q;
        lat_write_d  = lat_write_q;
        lat_ba_d     = lat_ba_q;
        lat_row_d    = lat_row_q;
        lat_col_d    = lat_col_q;
        open_valid_d = open_valid_q;
        open_row_d   = open_row_q;
        req_ready_d  = '0;
        commands_d   = '0;
        ba_d         = ba;
        row_d        = row;
        column_d     = column;
        dq_oe_d      = 1'b0;
        done_d       = 1'b0;
        done_id_d    = done_id;

        if (!halt) begin
            unique case (state_q)
                StIdle: begin
                    if (grant_found) begin
                        req_ready_d[grant_id] = 1'b1;
                        ptr_d       = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
                        lat_id_d    = grant_id;
                        lat_write_d = req_write[grant_id];
                        lat_ba_d    = g_ba;
                        lat_row_d   = g_row;
                        lat_col_d   = g_col;
                        beat_d      = '0;
                        if (!open_valid_q[g_bank]) begin
                            state_d = StAct;
                        end else if (open_row_q[g_bank] == g_row) begin
                            state_d = StBurst;
                        end else begin
                            state_d = StPre;
                        end
                    end
                end
                StPre: begin
                    commands_d[7]          = 1'b1;
                    ba_d                   = lat_ba_q;
                    open_valid_d[lat_bank] = 1'b0;
                    if (TRP > 1) begin
                        state_d = StWaitRp;
                        cnt_d   = CNTW'(TRP - 2);
                    end else begin
                        state_d = StAct;
                    end
                end
                StWaitRp: begin
                    if (cnt_q == '0) state_d = StAct;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                StAct: begin
                    commands_d[18]         = 1'b1;
                    ba_d                   = lat_ba_q;
                    row_d                  = lat_row_q;
                    open_valid_d[lat_bank] = 1'b1;
                    open_row_d[lat_bank]   = lat_row_q;
                    if (TRCD > 1) begin
                        state_d = StWaitRcd;
                        cnt_d   = CNTW'(TRCD - 2);
                    end else begin
                        state_d = StBurst;
                    end
                end
                StWaitRcd: begin
                    if (cnt_q == '0) state_d = StBurst;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                StBurst: begin
                    commands_d[lat_write_q ? 1 : 5] = 1'b1;
                    ba_d     = lat_ba_q;
                    row_d    = lat_row_q;
                    // Wrap the beat within the BL-aligned column block.
                    column_d = lat_col_q;
                    column_d[LBW-1:0] = lat_col_q[LBW-1:0] + beat_q;
                    dq_oe_d  = lat_write_q;
                    if (beat_q == LBW'(BL - 1)) begin
                        done_d    = 1'b1;
                        done_id_d = lat_id_q;
                        state_d   = StIdle;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            cnt_q        <= '0;
            beat_q       <= '0;
            lat_id_q     <= '0;
            lat_write_q  <= 1'b0;
            lat_ba_q     <= '0;
            lat_row_q    <= '0;
            lat_col_q    <= '0;
            open_valid_q <= '0;
            for (int b = 0; b < BANKSPERGROUP; b++) begin
                open_row_q[b] <= '0;
            end
            req_ready    <= '0;
            commands     <= '0;
            ba           <= '0;
            row          <= '0;
            column       <= '0;
            dq_oe        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_id      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            lat_id_q     <= lat_id_d;
            lat_write_q  <= lat_write_d;
            lat_ba_q     <= lat_ba_d;
            lat_row_q    <= lat_row_d;
            lat_col_q    <= lat_col_d;
            open_valid_q <= open_valid_d;
            open_row_q   <= open_row_d;
            req_ready    <= req_ready_d;
            commands     <= commands_d;
            ba           <= ba_d;
            row          <= row_d;
            column       <= column_d;
            dq_oe        <= dq_oe_d;
            busy         <= busy_d;
            done         <= done_d;
            done_id      <= done_id_d;
        end
    end

endmodule

// File: tb/tb_bg_cmd_scheduler.sv
// Bench for bg_cmd_scheduler: a command-slot queue model checked every cycle, plus
// directed scenarios with literal timing and column expectations.
module tb_bg_cmd_scheduler;

    localparam int N    = 2;
    localparam int AW   = 17;
    localparam int BW   = 2;
    localparam int CW   = 10;
    localparam int BL   = 8;
    localparam int TRP  = 3;
    localparam int TRCD = 3;

    logic            clk = 1'b0;
    logic            reset, halt;
    logic [N-1:0]    req_valid, req_write, req_ready;
    logic [N*BW-1:0] req_ba;
    logic [N*AW-1:0] req_row;
    logic [N*CW-1:0] req_col;
    logic [18:0]     commands;
    logic [BW-1:0]   ba;
    logic [AW-1:0]   row;
    logic [CW-1:0]   column;
    logic            dq_oe, busy, done;
    logic            done_id;

    bg_cmd_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .halt      (halt),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_ready (req_ready),
        .commands  (commands),
        .ba        (ba),
        .row       (row),
        .column    (column),
        .dq_oe     (dq_oe),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- model: each non-halted cycle after an accept consumes one slot
    typedef struct {
        int kind;  // 0 idle, 1 PRE, 2 ACT, 3 beat
        int ba;
        int row;
        int col;
        bit wr;
        int id;
        bit last;
    } slot_t;

    slot_t q[$];
    bit    tv[2];
    int    tr[2];
    int    ptr;
    bit    model_on = 0;
    int    e_ready, e_cmd, e_ba, e_row, e_col, e_dq, e_busy, e_done, e_did;

    logic            s_reset, s_halt;
    logic [N-1:0]    s_valid, s_write;
    logic [N*BW-1:0] s_ba;
    logic [N*AW-1:0] s_row;
    logic [N*CW-1:0] s_col;

    task automatic push(input int kind, input int b, input int r, input int c, input bit w,
                        input int id, input bit last);
        slot_t s;
        s.kind = kind; s.ba = b; s.row = r; s.col = c; s.wr = w; s.id = id; s.last = last;
        q.push_back(s);
    endtask

    task automatic model_step();
        int g, fb, fr, fc, bank;
        bit fw;
        slot_t s;
        if (s_reset) begin
            model_on = 1;
            q.delete();
            tv[0] = 0; tv[1] = 0; tr[0] = 0; tr[1] = 0; ptr = 0;
            e_ready = 0; e_cmd = 0; e_ba = 0; e_row = 0; e_col = 0;
            e_dq = 0; e_busy = 0; e_done = 0; e_did = 0;
            return;
        end
        e_ready = 0; e_cmd = 0; e_dq = 0; e_done = 0;
        if (s_halt) begin
            e_busy = (q.size() != 0);
            return;
        end
        if (q.size() == 0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && s_valid[(ptr + k) % N]) g = (ptr + k) % N;
            end
            if (g >= 0) begin
                e_ready = 1 << g;
                ptr = (g + 1) % N;
                fb = int'(s_ba[g*BW +: BW]);
                fr = int'(s_row[g*AW +: AW]);
                fc = int'(s_col[g*CW +: CW]);
                fw = s_write[g];
                bank = fb % 2;
                if (!(tv[bank] && tr[bank] == fr)) begin
                    if (tv[bank]) begin
                        push(1, fb, fr, 0, fw, g, 0);
                        for (int k = 0; k < TRP - 1; k++) push(0, 0, 0, 0, 0, 0, 0);
                    end
                    push(2, fb, fr, 0, fw, g, 0);
                    for (int k = 0; k < TRCD - 1; k++) push(0, 0, 0, 0, 0, 0, 0);
                end
                for (int k = 0; k < BL; k++) begin
                    push(3, fb, fr, (fc / BL) * BL + (fc + k) % BL, fw, g, k == BL - 1);
                end
                tv[bank] = 1;
                tr[bank] = fr;
            end
        end else begin
            s = q.pop_front();
            case (s.kind)
                1: begin e_cmd = 1 << 7; e_ba = s.ba; end
                2: begin e_cmd = 1 << 18; e_ba = s.ba; e_row = s.row; end
                3: begin
                    e_cmd = s.wr ? (1 << 1) : (1 << 5);
                    e_ba = s.ba; e_row = s.row; e_col = s.col; e_dq = int'(s.wr);
                    e_done = int'(s.last);
                    if (s.last) e_did = s.id;
                end
                default: ;
            endcase
        end
        e_busy = (q.size() != 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            s_reset = reset; s_halt = halt; s_valid = req_valid; s_write = req_write;
            s_ba = req_ba; s_row = req_row; s_col = req_col;
            model_step();
            @(negedge clk);
            if (model_on) begin
                chk("req_ready", int'(req_ready), e_ready);
                chk("commands", int'(commands), e_cmd);
                chk("ba", int'(ba), e_ba);
                chk("row", int'(row), e_row);
                chk("column", int'(column), e_col);
                chk("dq_oe", int'(dq_oe), e_dq);
                chk("busy", int'(busy), e_busy);
                chk("done", int'(done), e_done);
                if (e_done != 0) chk("done_id", int'(done_id), e_did);
            end
        end
    end

    // ---------------- directed stimulus and literal observations
    int t_acc, pre_off, act_off, first_off, done_off, done_idv, dq_cnt, last_done;
    int beats[$];

    task automatic set_req(input int i, input bit w, input int b, input int r, input int c);
        req_write[i]         = w;
        req_ba[i*BW +: BW]   = BW'(b);
        req_row[i*AW +: AW]  = AW'(r);
        req_col[i*CW +: CW]  = CW'(c);
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        bit got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        chk("accept_seen", int'(got), 1);
        t_acc = cyc;
        req_valid[i] = 1'b0;
    endtask

    task automatic watch(input int n, input int h_at, input int h_len);
        int off;
        pre_off = -1; act_off = -1; first_off = -1; done_off = -1; done_idv = -1; dq_cnt = 0;
        beats.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            off = cyc - t_acc;
            if (commands[7]) pre_off = off;
            if (commands[18]) act_off = off;
            if (commands[5] || commands[1]) begin
                if (first_off < 0) first_off = off;
                beats.push_back(int'(column));
                if (dq_oe) dq_cnt++;
            end
            if (done) begin done_off = off; done_idv = int'(done_id); end
            if (off == h_at) halt = 1'b1;
            if (off == h_at + h_len) halt = 1'b0;
        end
    endtask

    task automatic chk_cols(input int exp[8]);
        chk("beat_count", beats.size(), 8);
        for (int k = 0; k < 8; k++) chk("beat_col", (k < beats.size()) ? beats[k] : -1, exp[k]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid, gcyc;
        bit seen;
        reset = 1'b1; halt = 1'b0;
        req_valid = '0; req_write = '0; req_ba = '0; req_row = '0; req_col = '0;
        repeat (3) @(negedge clk);
        chk("reset_commands", int'(commands), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // closed bank read
        set_req(0, 0, 1, 5, 3);
        wait_accept(0);
        watch(12, -100, 0);
        chk("t1_pre", pre_off, -1);
        chk("t1_act", act_off, 1);
        chk("t1_first", first_off, 4);
        chk("t1_done", done_off, 11);
        chk("t1_done_id", done_idv, 0);
        chk_cols('{3, 4, 5, 6, 7, 0, 1, 2});

        // row hit write
        set_req(0, 1, 1, 5, 8);
        wait_accept(0);
        watch(9, -100, 0);
        chk("t2_act", act_off, -1);
        chk("t2_first", first_off, 1);
        chk("t2_done", done_off, 8);
        chk("t2_dq", dq_cnt, 8);
        chk_cols('{8, 9, 10, 11, 12, 13, 14, 15});

        // row conflict write from requester 1
        set_req(1, 1, 1, 9, 0);
        wait_accept(1);
        watch(15, -100, 0);
        chk("t3_pre", pre_off, 1);
        chk("t3_act", act_off, 4);
        chk("t3_first", first_off, 7);
        chk("t3_done", done_off, 14);
        chk("t3_done_id", done_idv, 1);

        // both requesters held valid: grants alternate, one cycle after each done
        set_req(0, 0, 0, 2, 0);
        set_req(1, 1, 1, 9, 5);
        last_done = 0;
        for (int g = 0; g < 4; g++) begin
            seen = 0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                if (req_ready != '0) seen = 1;
            end
            chk("rr_accept_seen", int'(seen), 1);
            gid = req_ready[1] ? 1 : 0;
            gcyc = cyc;
            chk("rr_grant", gid, g % 2);
            if (g > 0) chk("rr_gap", gcyc - last_done, 1);
            if (g == 3) req_valid = '0;
            seen = 0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            chk("rr_done_seen", int'(seen), 1);
            last_done = cyc;
        end

        // halt for 4 cycles over beat 3 of a hit read
        set_req(0, 0, 0, 2, 6);
        wait_accept(0);
        watch(14, 3, 4);
        chk("t5_first", first_off, 1);
        chk("t5_done", done_off, 12);
        chk_cols('{6, 7, 0, 1, 2, 3, 4, 5});

        // reset during WAIT_RCD of a conflict write
        set_req(1, 1, 1, 4, 0);
        wait_accept(1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ba", int'(ba), 0);
        chk("t6_row", int'(row), 0);
        chk("t6_commands", int'(commands), 0);
        reset = 1'b0;
        watch(14, -100, 0);
        chk("t6_no_beat", first_off, -1);
        chk("t6_no_done", done_off, -1);

        // same bank again, held off by halt in IDLE: table was cleared, so ACT first
        halt = 1'b1;
        set_req(1, 1, 1, 4, 0);
        repeat (3) @(negedge clk);
        halt = 1'b0;
        wait_accept(1);
        watch(12, -100, 0);
        chk("t7_pre", pre_off, -1);
        chk("t7_act", act_off, 1);
        chk("t7_first", first_off, 4);
        chk("t7_done", done_off, 11);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
